// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the router packet transmitter:
//   - state_e      : transmitter FSM states
//   - BYTE_W       : width of every byte on the payload and router sides
//   - MAX_LEN      : longest payload a command may request
//   - LEN_W/ADDR_W : widths of the command length and address fields
//   - ADDR_INVALID : destination code that is rejected at command time
//   - make_header  : builds the {len, addr} header byte
package router_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_LEN = 63;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int ADDR_W  = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  // Length occupies the upper six bits, destination the lower two.
  function automatic logic [BYTE_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
//   Payload staging buffer, (MAX_LEN+1) x BYTE_W, one synchronous write port
//   and one combinational read port. Contents are not reset.
//   Ports:
//     clk_i   : write clock
//     we_i    : write enable
//     waddr_i : write index
//     wdata_i : write byte
//     raddr_i : read index
//     rdata_o : byte at raddr_i (combinational)
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [LEN_W-1:0]  raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  localparam int DEPTH = MAX_LEN + 1;

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//   Accepts a packet command (destination + length), collects the payload
//   bytes into a local buffer, then streams header, payload and an XOR
//   parity byte to the router, honouring the router's busy stall.
//   Ports:
//     clock, resetn          : clock, asynchronous active-low reset
//     cmd_valid/cmd_ready    : command handshake (ready only when idle)
//     cmd_addr, cmd_len      : destination 0..2, payload length 1..63
//     pl_valid/pl_ready      : upstream payload byte handshake
//     pl_data                : payload byte
//     busy                   : router stall, freezes the outgoing byte
//     data_out, pkt_valid    : registered byte / valid strobe to the router
//     tx_done                : one-cycle pulse after the parity byte
//     cmd_err                : one-cycle pulse for an illegal command
//     inj_parity_err         : present only with ROUTER_PKT_TX_PARITY_INJ_EN;
//                              sampled at command accept, flips parity bit 0
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              pl_valid,
  input  logic [BYTE_W-1:0] pl_data,
  output logic              pl_ready,
  input  logic              busy,
  output logic [BYTE_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_done,
  output logic              cmd_err
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
  ,
  input  logic              inj_parity_err
`endif
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] parity_q, parity_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              tx_done_q, tx_done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              inj_q, inj_d;
  logic              inj_sample;

  logic              buf_we;
  logic [LEN_W-1:0]  buf_raddr;
  logic [BYTE_W-1:0] buf_rdata;
  logic [BYTE_W-1:0] header;
  logic [LEN_W-1:0]  last_idx;

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
  assign inj_sample = inj_parity_err;
`else
  assign inj_sample = 1'b0;
`endif

  assign header   = make_header(len_q, addr_q);
  assign last_idx = len_q - LEN_W'(1);

  // The output register always holds the byte currently on the wire, so the
  // read port looks one byte ahead: byte 0 while the header is out, idx+1
  // while payload byte idx is out.
  assign buf_raddr = (state_q == ST_HEADER) ? '0 : idx_q + LEN_W'(1);

  router_tx_buf u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (pl_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      parity_q    <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      parity_q    <= parity_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      tx_done_q   <= tx_done_d;
      cmd_err_q   <= cmd_err_d;
      inj_q       <= inj_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    addr_d      = addr_q;
    parity_d    = parity_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    tx_done_d   = 1'b0;
    cmd_err_d   = 1'b0;
    inj_d       = inj_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if ((cmd_addr == ADDR_INVALID) || (cmd_len == '0)) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            len_d    = cmd_len;
            parity_d = '0;
            idx_d    = '0;
            inj_d    = inj_sample;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (pl_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pl_data;
          if (idx_q == last_idx) begin
            // Header goes out on the very next cycle and joins the parity.
            parity_d    = parity_q ^ pl_data ^ header;
            idx_d       = '0;
            data_out_d  = header;
            pkt_valid_d = 1'b1;
            state_d     = ST_HEADER;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      ST_HEADER: begin
        if (!busy) begin
          data_out_d = buf_rdata;
          idx_d      = '0;
          state_d    = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (!busy) begin
          if (idx_q == last_idx) begin
            data_out_d  = parity_q ^ {{(BYTE_W-1){1'b0}}, inj_q};
            pkt_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = ST_PARITY;
          end else begin
            data_out_d = buf_rdata;
            idx_d      = idx_q + LEN_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (!busy) begin
          tx_done_d = 1'b1;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign pl_ready  = (state_q == ST_LOAD);
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign tx_done   = tx_done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx
//   Randomised bench for router_pkt_tx. The expected wire stream of each
//   packet is built as a list of (byte, valid) pairs from the packet fields;
//   the bench walks that list, advancing one entry per cycle in which busy
//   was low. Build with ROUTER_PKT_TX_PARITY_INJ_EN to cover parity injection.
module tb_router_pkt_tx;
  import router_pkg::*;

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  logic        clock;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_ready;
  logic        busy;
  logic [7:0]  data_out;
  logic        pkt_valid;
  logic        tx_done;
  logic        cmd_err;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
  logic        inj_parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] pay    [64];
  logic [7:0] exp_b  [66];
  logic       exp_v  [66];

  router_pkt_tx dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_done   (tx_done),
    .cmd_err   (cmd_err)
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    ,
    .inj_parity_err (inj_parity_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One packet: command, payload load, wire stream, tx_done, back to idle.
  // pv_mode : 0 = pl_valid always high, 1 = every other cycle, 2 = random
  // bmode   : 0 = no stall, 1 = two stall cycles on wire entry 2, 2 = random
  // abort_k : wire entry at which resetn is pulsed (-1 = none)
  task automatic run_pkt(input logic [1:0] a, input int l, input int pv_mode,
                         input int bmode, input bit inj, input int abort_k);
    int n, acc, cyc, k, stalls;
    logic v, b, inj_eff;
    logic [7:0] par;

    inj_eff = inj & INJ_ON;
    exp_b[0] = {6'(l), a};
    exp_v[0] = 1'b1;
    par = exp_b[0];
    for (int i = 0; i < l; i++) begin
      exp_b[i+1] = pay[i];
      exp_v[i+1] = 1'b1;
      par = par ^ pay[i];
    end
    par[0] = par[0] ^ inj_eff;
    exp_b[l+1] = par;
    exp_v[l+1] = 1'b0;

    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("idle_ready", 32'(cmd_ready), 32'(1));

    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 6'(l);
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    inj_parity_err = inj;
`endif
    @(negedge clock);
    cmd_valid = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    inj_parity_err = 1'($urandom_range(0, 1));
`endif
    check_val("load_cmd_ready", 32'(cmd_ready), 32'(0));
    check_val("load_pl_ready", 32'(pl_ready), 32'(1));

    acc = 0;
    cyc = 0;
    while (acc < l && cyc < 2000) begin
      check_val("load_quiet", 32'(pkt_valid), 32'(0));
      case (pv_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      pl_valid = v;
      pl_data  = v ? pay[acc] : 8'($urandom);
      if (bmode == 2) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = 2'($urandom);
        cmd_len   = 6'($urandom);
      end
      @(negedge clock);
      if (v) acc++;
      cyc++;
    end
    check_val("load_count", 32'(acc), 32'(l));
    pl_valid = 1'b0;

    k = 0;
    stalls = 0;
    cyc = 0;
    while (k < l + 2 && cyc < 2000) begin
      check_val("wire_byte", 32'(data_out), 32'(exp_b[k]));
      check_val("wire_valid", 32'(pkt_valid), 32'(exp_v[k]));
      check_val("wire_pl_ready", 32'(pl_ready), 32'(0));
      check_val("wire_tx_done", 32'(tx_done), 32'(0));
      if (k == abort_k) begin
        #2 resetn = 1'b0;
        #1;
        check_val("abort_pkt_valid", 32'(pkt_valid), 32'(0));
        check_val("abort_data_out", 32'(data_out), 32'(0));
        check_val("abort_cmd_ready", 32'(cmd_ready), 32'(1));
        busy      = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) begin
          @(negedge clock);
          check_val("abort_quiet", 32'(pkt_valid), 32'(0));
          check_val("abort_no_done", 32'(tx_done), 32'(0));
        end
        $display("pkt addr=%0d len=%0d aborted at wire entry %0d", a, l, k);
        return;
      end
      case (bmode)
        1:       b = (k == 2 && stalls < 2);
        2:       b = ($urandom_range(0, 3) == 0);
        default: b = 1'b0;
      endcase
      if (b) stalls++;
      busy = b;
      if (bmode == 2) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = 2'($urandom);
        cmd_len   = 6'($urandom);
      end
      @(negedge clock);
      if (!b) k++;
      cyc++;
    end
    check_val("wire_entries", 32'(k), 32'(l + 2));
    busy      = 1'b0;
    cmd_valid = 1'b0;

    check_val("gap_tx_done", 32'(tx_done), 32'(1));
    check_val("gap_pkt_valid", 32'(pkt_valid), 32'(0));
    check_val("gap_data_out", 32'(data_out), 32'(par));
    @(negedge clock);
    check_val("post_tx_done", 32'(tx_done), 32'(0));
    check_val("post_cmd_ready", 32'(cmd_ready), 32'(1));
    $display("pkt addr=%0d len=%0d hdr=%02h parity=%02h stalls=%0d inj=%0d", a, l, exp_b[0], par, stalls, inj_eff);
  endtask

  task automatic cmd_err_test(input logic [1:0] a, input logic [5:0] l);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clock);
    cmd_valid = 1'b0;
    check_val("err_pulse", 32'(cmd_err), 32'(1));
    check_val("err_cmd_ready", 32'(cmd_ready), 32'(1));
    check_val("err_pkt_valid", 32'(pkt_valid), 32'(0));
    check_val("err_pl_ready", 32'(pl_ready), 32'(0));
    @(negedge clock);
    check_val("err_pulse_end", 32'(cmd_err), 32'(0));
    check_val("err_still_idle", 32'(cmd_ready), 32'(1));
    $display("cmd_err addr=%0d len=%0d", a, l);
  endtask

  initial begin
    int l;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    pl_valid  = 1'b0;
    pl_data   = '0;
    busy      = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    inj_parity_err = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check_val("rst_data_out", 32'(data_out), 32'(0));
    check_val("rst_pkt_valid", 32'(pkt_valid), 32'(0));
    check_val("rst_tx_done", 32'(tx_done), 32'(0));
    check_val("rst_cmd_err", 32'(cmd_err), 32'(0));
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check_val("rst_pl_ready", 32'(pl_ready), 32'(0));
    resetn = 1'b1;
    @(negedge clock);

    // Reference packet, no stall, then the same packet with a stall on 22.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt(2'd1, 3, 0, 0, 1'b0, -1);
    run_pkt(2'd1, 3, 0, 1, 1'b0, -1);

    // Illegal commands.
    cmd_err_test(2'd3, 6'd5);
    cmd_err_test(2'd2, 6'd0);
    cmd_err_test(2'd3, 6'd0);

    // Longest packet with a half-rate payload source.
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    run_pkt(2'd0, 63, 1, 0, 1'b0, -1);

    // Shortest packet.
    pay[0] = 8'($urandom);
    run_pkt(2'd2, 1, 0, 0, 1'b0, -1);

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt(2'd1, 3, 0, 0, 1'b1, -1);
    check_val("inj_parity_0c", 32'(data_out), 32'(8'h0C));
`endif

    // Reset in the middle of the payload, then a clean packet.
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    run_pkt(2'd2, 10, 0, 0, 1'b0, 4);
    run_pkt(2'd1, 5, 0, 0, 1'b0, -1);

    // Random traffic with random stalls and payload gaps.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(1, 12));
      run_pkt(2'($urandom_range(0, 2)), l, 2, 2, 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
